// File: rtl/layer_mux_pipe_if.sv
// Bus bundle for layer_mux_pipe.
// Groups the pixel-side inputs (valid/sof strobes, layer requests, layer and
// background colours) and the mixed outputs (RGB, winner index, collision
// flags). The "master" modport belongs to the pixel source/sink side and
// "slave" to the mixer itself.
//   pix_valid, sof        : per-pixel strobes
//   draw_req, layer_rgb   : per-layer request and packed {r,g,b}
//   bg_rgb                : background colour
//   red/green/blue_out    : mixed colour, 2 cycles after input
//   out_valid, out_layer  : delayed valid, winning layer (4'hF = background)
//   col_now/live/frame    : collision on this pixel / this frame / last frame
interface layer_mux_pipe_if #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 4
);
  localparam int NUM_PAIRS = NUM_LAYERS * (NUM_LAYERS - 1) / 2;

  logic                            pix_valid;
  logic                            sof;
  logic [NUM_LAYERS-1:0]           draw_req;
  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb;
  logic [3*COLOR_W-1:0]            bg_rgb;
  logic [COLOR_W-1:0]              red_out;
  logic [COLOR_W-1:0]              green_out;
  logic [COLOR_W-1:0]              blue_out;
  logic                            out_valid;
  logic [3:0]                      out_layer;
  logic                            col_now;
  logic [NUM_PAIRS-1:0]            col_live;
  logic [NUM_PAIRS-1:0]            col_frame;

  modport master (
    output pix_valid, sof, draw_req, layer_rgb, bg_rgb,
    input  red_out, green_out, blue_out, out_valid, out_layer,
           col_now, col_live, col_frame
  );

  modport slave (
    input  pix_valid, sof, draw_req, layer_rgb, bg_rgb,
    output red_out, green_out, blue_out, out_valid, out_layer,
           col_now, col_live, col_frame
  );
endinterface

// File: rtl/layer_mux_pipe.sv
// Pipelined fixed-priority layer mixer with transparency and per-frame
// pairwise collision flags. Layer 0 has the highest priority; with no
// effective request the background colour is passed through.
// Ports:
//   clk   : pixel clock
//   reset : asynchronous, active-high
//   bus   : layer_mux_pipe_if.slave (all pixel inputs and mixed outputs)
// Latency is two cycles; the pipeline never stalls.
module layer_mux_pipe #(
  parameter int                     NUM_LAYERS = 4,
  parameter int                     COLOR_W    = 4,
  parameter int                     TRANSP_EN  = 1,
  parameter logic [3*COLOR_W-1:0]   TRANSP_RGB = 12'h0F0
) (
  input  logic               clk,
  input  logic               reset,
  layer_mux_pipe_if.slave    bus
);
  localparam int RGB_W     = 3 * COLOR_W;
  localparam int NUM_PAIRS = NUM_LAYERS * (NUM_LAYERS - 1) / 2;

  // Effective requests: a layer showing the transparent key does not draw.
  logic [NUM_LAYERS-1:0] eff;
  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_eff
      logic transp_hit;
      assign transp_hit = (TRANSP_EN != 0) &&
                          (bus.layer_rgb[gi*RGB_W +: RGB_W] == TRANSP_RGB);
      assign eff[gi] = bus.draw_req[gi] & ~transp_hit;
    end
  endgenerate

  // Priority select: scanning from the lowest priority upward lets the
  // lowest-indexed requesting layer overwrite everything below it.
  logic [3:0]       win_idx;
  logic [RGB_W-1:0] win_rgb;
  always_comb begin
    win_idx = 4'hF;
    win_rgb = bus.bg_rgb;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eff[i]) begin
        win_idx = 4'(i);
        win_rgb = bus.layer_rgb[i*RGB_W +: RGB_W];
      end
    end
  end

  // Stage 1
  logic [NUM_LAYERS-1:0] s1_eff_reg;
  logic [3:0]            s1_idx_reg;
  logic [RGB_W-1:0]      s1_rgb_reg;
  logic                  s1_valid_reg;
  logic                  s1_sof_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_eff_reg   <= '0;
      s1_idx_reg   <= 4'hF;
      s1_rgb_reg   <= '0;
      s1_valid_reg <= 1'b0;
      s1_sof_reg   <= 1'b0;
    end else begin
      s1_eff_reg   <= eff;
      s1_idx_reg   <= win_idx;
      s1_rgb_reg   <= win_rgb;
      s1_valid_reg <= bus.pix_valid;
      s1_sof_reg   <= bus.sof;
    end
  end

  // Pair hits from the stage-1 mask; pair (i,j) with i<j maps to bit
  // i*(2N-i-1)/2 + (j-i-1), giving (0,1),(0,2)..(N-2,N-1) in order.
  logic [NUM_PAIRS-1:0] pair_hit;
  generate
    for (genvar gi = 0; gi < NUM_LAYERS - 1; gi++) begin : g_pi
      for (genvar gj = gi + 1; gj < NUM_LAYERS; gj++) begin : g_pj
        localparam int P = gi * (2 * NUM_LAYERS - gi - 1) / 2 + (gj - gi - 1);
        assign pair_hit[P] = s1_eff_reg[gi] & s1_eff_reg[gj];
      end
    end
  endgenerate

  logic [NUM_PAIRS-1:0] hits_valid;
  logic                 multi_req;
  assign hits_valid = s1_valid_reg ? pair_hit : '0;
  // Two or more bits set <=> clearing the lowest set bit leaves something.
  assign multi_req  = |(s1_eff_reg & (s1_eff_reg - 1'b1));

  // Stage 2 and collision accumulators
  logic [RGB_W-1:0]     rgb_reg;
  logic [3:0]           layer_reg;
  logic                 valid_reg;
  logic                 now_reg;
  logic [NUM_PAIRS-1:0] live_reg;
  logic [NUM_PAIRS-1:0] frame_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_reg   <= '0;
      layer_reg <= 4'hF;
      valid_reg <= 1'b0;
      now_reg   <= 1'b0;
      live_reg  <= '0;
      frame_reg <= '0;
    end else begin
      rgb_reg   <= s1_rgb_reg;
      layer_reg <= s1_idx_reg;
      valid_reg <= s1_valid_reg;
      now_reg   <= s1_valid_reg & multi_req;
      // A sof slot closes the previous frame (without this pixel) and
      // starts the new accumulation with this pixel's hits only.
      if (s1_sof_reg) begin
        frame_reg <= live_reg;
        live_reg  <= hits_valid;
      end else begin
        live_reg  <= live_reg | hits_valid;
      end
    end
  end

  assign bus.red_out   = rgb_reg[2*COLOR_W +: COLOR_W];
  assign bus.green_out = rgb_reg[COLOR_W +: COLOR_W];
  assign bus.blue_out  = rgb_reg[0 +: COLOR_W];
  assign bus.out_layer = layer_reg;
  assign bus.out_valid = valid_reg;
  assign bus.col_now   = now_reg;
  assign bus.col_live  = live_reg;
  assign bus.col_frame = frame_reg;
endmodule

// File: tb/tb_layer_mux_pipe.sv
// Self-checking bench for layer_mux_pipe (4 layers, 4-bit colour).
// Expected outputs are computed from the driven stimulus and queued; each
// queued entry is compared when it reaches the output two cycles later.
module tb_layer_mux_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  layer_mux_pipe_if #(.NUM_LAYERS(4), .COLOR_W(4)) bus ();

  layer_mux_pipe #(
    .NUM_LAYERS(4), .COLOR_W(4), .TRANSP_EN(1), .TRANSP_RGB(12'h0F0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  typedef struct {
    logic [11:0] rgb;
    logic [3:0]  layer;
    logic        valid;
    logic        now;
    logic        sof;
    logic [5:0]  hits;
  } exp_t;

  exp_t q[$];
  logic [5:0] model_live;
  logic [5:0] model_frame;
  int tests_run = 0;
  int tests_failed = 0;
  int txn = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'h0);
    check({tag, "_rgb"}, {20'h0, bus.red_out, bus.green_out, bus.blue_out}, 32'h0);
    check({tag, "_layer"}, 32'(bus.out_layer), 32'hF);
    check({tag, "_now"}, 32'(bus.col_now), 32'h0);
    check({tag, "_live"}, 32'(bus.col_live), 32'(model_live));
    check({tag, "_frame"}, 32'(bus.col_frame), 32'(model_frame));
  endtask

  task automatic drive(input logic v, input logic s, input logic [3:0] req,
                       input logic [47:0] lr, input logic [11:0] bg);
    exp_t e;
    logic [3:0] eff;
    logic found;
    int p;
    eff = '0;
    for (int i = 0; i < 4; i++)
      eff[i] = req[i] && (lr[i*12 +: 12] != 12'h0F0);
    found = 1'b0;
    e.rgb = bg;
    e.layer = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (eff[i] && !found) begin
        found = 1'b1;
        e.rgb = lr[i*12 +: 12];
        e.layer = 4'(i);
      end
    end
    e.valid = v;
    e.now = v && ($countones(eff) >= 2);
    e.sof = s;
    e.hits = '0;
    p = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++) begin
        e.hits[p] = v && eff[i] && eff[j];
        p++;
      end
    q.push_back(e);
    bus.pix_valid = v;
    bus.sof = s;
    bus.draw_req = req;
    bus.layer_rgb = lr;
    bus.bg_rgb = bg;
    @(posedge clk);
    #1;
    if (q.size() >= 2) begin
      e = q.pop_front();
      if (e.sof) begin
        model_frame = model_live;
        model_live = e.hits;
      end else begin
        model_live = model_live | e.hits;
      end
      txn++;
      $display("[TB] txn %0d rgb=%h layer=%h valid=%0b now=%0b live=%b frame=%b",
               txn, {bus.red_out, bus.green_out, bus.blue_out}, bus.out_layer,
               bus.out_valid, bus.col_now, bus.col_live, bus.col_frame);
      check("rgb", {20'h0, bus.red_out, bus.green_out, bus.blue_out}, {20'h0, e.rgb});
      check("layer", 32'(bus.out_layer), 32'(e.layer));
      check("valid", 32'(bus.out_valid), 32'(e.valid));
      check("col_now", 32'(bus.col_now), 32'(e.now));
      check("col_live", 32'(bus.col_live), 32'(model_live));
      check("col_frame", 32'(bus.col_frame), 32'(model_frame));
    end else begin
      check_idle("fill");
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    q.delete();
    model_live = '0;
    model_frame = '0;
    check_idle("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [47:0] lr;
    logic [3:0]  req;
    bus.pix_valid = 1'b0;
    bus.sof = 1'b0;
    bus.draw_req = '0;
    bus.layer_rgb = '0;
    bus.bg_rgb = '0;
    model_live = '0;
    model_frame = '0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // background only
    drive(1, 1, 4'b0000, 48'h0, 12'h123);
    // layers 1 and 2 collide, layer 1 wins
    drive(1, 0, 4'b0110, {12'h000, 12'h0B0, 12'hA00, 12'h000}, 12'h123);
    // layer 0 transparent, layer 1 wins, no collision
    drive(1, 0, 4'b0011, {12'h000, 12'h000, 12'h00C, 12'h0F0}, 12'h123);
    // collide (0,3), then clean sof, then another clean sof
    drive(1, 0, 4'b1001, {12'h00F, 12'h000, 12'h000, 12'hF00}, 12'h456);
    drive(1, 1, 4'b0000, 48'h0, 12'h456);
    drive(1, 0, 4'b0001, {36'h0, 12'h777}, 12'h456);
    drive(1, 1, 4'b0000, 48'h0, 12'h456);
    drive(1, 0, 4'b0000, 48'h0, 12'h456);
    // collision that pix_valid masks out, then sof with a (0,1) collision
    drive(0, 0, 4'b1111, {12'h444, 12'h333, 12'h222, 12'h111}, 12'h000);
    drive(1, 1, 4'b0011, {24'h0, 12'h222, 12'h111}, 12'h000);
    // sof without pix_valid, back-to-back sof
    drive(0, 1, 4'b0011, {24'h0, 12'h222, 12'h111}, 12'h000);
    drive(1, 1, 4'b0000, 48'h0, 12'h000);
    drive(1, 0, 4'b0000, 48'h0, 12'h000);

    for (int n = 0; n < 200; n++) begin
      req = 4'($urandom_range(15));
      for (int i = 0; i < 4; i++)
        lr[i*12 +: 12] = ($urandom_range(3) == 0) ? 12'h0F0 : 12'($urandom);
      drive($urandom_range(3) != 0, $urandom_range(15) == 0, req, lr, 12'($urandom));
    end

    // reset mid-frame with accumulated collisions
    drive(1, 0, 4'b0011, {24'h0, 12'h222, 12'h111}, 12'h000);
    drive(1, 0, 4'b1100, {12'h444, 12'h333, 24'h0}, 12'h000);
    apply_reset();
    drive(1, 0, 4'b0100, {12'h000, 12'h9AB, 24'h0}, 12'h321);
    drive(1, 0, 4'b0000, 48'h0, 12'h321);
    drive(1, 1, 4'b0101, {12'h000, 12'hCDE, 12'h000, 12'h567}, 12'h321);
    drive(0, 0, 4'b0000, 48'h0, 12'h000);
    drive(0, 0, 4'b0000, 48'h0, 12'h000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
